// File: rtl/piso_serializer_8bit.sv
// piso_serializer_8bit: parallel-in, serial-out transmitter, MSB first.
// Accepts a word on a valid/ready handshake and strobes it out one bit per bit period.
//
// Ports:
//   CLK          rising-edge clock
//   RESET        asynchronous, active-low reset
//   LOAD_VALID   upstream presents a word on LOAD_DATA
//   LOAD_DATA    word to transmit, sampled only on the accept edge
//   LOAD_READY   block can accept a word (IDLE)
//   DATA_OUT     serial bit, MSB first (0 while idle)
//   SHIFT_ENABLE receiver samples DATA_OUT on the edge ending this cycle
//   BUSY         frame in progress
//   DONE         one-cycle pulse after the last bit was strobed
module piso_serializer_8bit #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD_VALID,
    input  logic [WIDTH-1:0] LOAD_DATA,
    output logic             LOAD_READY,
    output logic             DATA_OUT,
    output logic             SHIFT_ENABLE,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_n;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_n;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_n;
    logic             done_r;
    logic             done_n;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            done_r    <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            bit_cnt   <= bit_n;
            div_cnt   <= div_n;
            done_r    <= done_n;
        end
    end

    // Strobe depends only on registers, so the receiver never sees an
    // input-to-output combinational path through this block.
    assign LOAD_READY   = (state == IDLE);
    assign BUSY         = (state == SHIFT);
    assign SHIFT_ENABLE = BUSY && (div_cnt == DIV_LAST);
    assign DATA_OUT     = BUSY && shift_reg[WIDTH-1];
    assign DONE         = done_r;

    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        bit_n   = bit_cnt;
        div_n   = div_cnt;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (LOAD_VALID) begin
                    shift_n = LOAD_DATA;
                    bit_n   = '0;
                    div_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (SHIFT_ENABLE) begin
                    div_n   = '0;
                    shift_n = {shift_reg[WIDTH-2:0], 1'b0};
                    bit_n   = bit_cnt + 1'b1;
                    // Last bit strobed: leave SHIFT and flag completion
                    // for exactly the following cycle.
                    if (bit_cnt == BIT_LAST) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: doc/piso_serializer_8bit.md
# piso_serializer_8bit

Parallel-in, serial-out transmitter that accepts a word over a valid/ready handshake and shifts it out MSB-first, one bit per bit period. It is the transmit end of our serial link. DATA_OUT and SHIFT_ENABLE drive the serial input and shift enable of our 8-bit shift-in receiver directly, in the same clock domain. After one frame, the receiver's parallel output equals the loaded word.

## Interface
- WIDTH, default 8: frame length in bits; legal range ≥ 2.
- CLKS_PER_BIT, default 1: CLK cycles per bit period; legal range ≥ 1.
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset. RESET is asynchronous, active-low; clock is CLK.
- LOAD_VALID  in  1  upstream presents a word on LOAD_DATA.
- LOAD_DATA  in  WIDTH  word to transmit; sampled only on an accept edge.
- LOAD_READY  out  1  block can accept a word (high in IDLE).
- DATA_OUT  out  1  serial bit, MSB first.
- SHIFT_ENABLE  out  1  one-cycle strobe; the receiver samples DATA_OUT on this CLK edge.
- BUSY  out  1  frame in progress (high in SHIFT).
- DONE  out  1  one-cycle pulse after the last bit has been strobed.

## Operation
- Internal state:
  - shift_reg [WIDTH-1:0].
  - bit_cnt, $clog2(WIDTH) bits.
  - div_cnt, max(1,$clog2(CLKS_PER_BIT)) bits.
  - FSM with two states, IDLE and SHIFT.
  - Registered DONE.
- Values on asynchronous RESET assertion:
  - FSM = IDLE.
  - shift_reg, bit_cnt, div_cnt = 0.
  - DONE = 0.
  - Outputs: LOAD_READY=1, BUSY=0, DATA_OUT=0, SHIFT_ENABLE=0.
- Accept: in IDLE, a rising edge with LOAD_VALID=1 loads LOAD_DATA into shift_reg. The same edge clears bit_cnt and div_cnt and moves the FSM to SHIFT.
- LOAD_READY = (FSM==IDLE). LOAD_VALID while in SHIFT is ignored, and LOAD_DATA is not sampled.
- DATA_OUT = shift_reg[WIDTH-1] in SHIFT, 0 in IDLE.
- SHIFT_ENABLE = (FSM==SHIFT) && (div_cnt==CLKS_PER_BIT-1). It is combinational from registers and never depends on inputs.
- Each SHIFT cycle:
  - If SHIFT_ENABLE=0: div_cnt increments.
  - If SHIFT_ENABLE=1: div_cnt returns to 0, shift_reg shifts left filling with 0, and bit_cnt increments.
- Frame end: on the SHIFT_ENABLE edge where bit_cnt==WIDTH-1, the FSM returns to IDLE and DONE is set to 1 for exactly the next cycle.
- Bit order: LOAD_DATA[WIDTH-1] is sent first and LOAD_DATA[0] last. This matches the receiver's shift toward bit WIDTH-1.
- RESET mid-frame: the frame is discarded immediately. No DONE is generated, and the block is ready for a new word on the first edge after RESET deasserts.

## Timing
- Accept edge = edge 0.
- SHIFT occupies cycles 1..WIDTH*CLKS_PER_BIT.
- SHIFT_ENABLE is high in cycles k*CLKS_PER_BIT, for k = 1..WIDTH.
- DONE and LOAD_READY are both high in cycle WIDTH*CLKS_PER_BIT+1.
- BUSY is high for exactly WIDTH*CLKS_PER_BIT cycles.
- DATA_OUT is stable for the whole bit period. It changes only on the edge after a SHIFT_ENABLE cycle.
- Back-to-back frames: a word presented with LOAD_VALID held high is accepted on the edge ending the DONE cycle. The minimum frame-to-frame period is WIDTH*CLKS_PER_BIT+1 cycles.
- CLKS_PER_BIT=1: SHIFT_ENABLE is high continuously for WIDTH cycles.

## Test plan
- Reset and idle:
  - Stimulus: assert RESET for 3 cycles, then release with LOAD_VALID=0 for 10 cycles.
  - Required: LOAD_READY=1; BUSY, DATA_OUT, SHIFT_ENABLE and DONE stay 0.
- Single frame, CLKS_PER_BIT=1, loopback into the receiver:
  - Stimulus: load 8'hA5.
  - Required: DATA_OUT during the 8 strobes = 1,0,1,0,0,1,0,1. DONE high in cycle 9. The receiver's q = 8'hA5 in that cycle.
- CLKS_PER_BIT=4:
  - Stimulus: load 8'h3C.
  - Required: SHIFT_ENABLE high in cycles 4,8,…,32 only. Each bit is held for 4 cycles. BUSY is high for 32 cycles. DONE is high in cycle 33. The receiver's q = 8'h3C.
- Back-to-back with busy-time loads:
  - Stimulus: hold LOAD_VALID=1 with 8'hFF, then switch to 8'h00 while BUSY.
  - Required: the first frame transmits 8'hFF unchanged. The second word, 8'h00, is accepted exactly on the DONE edge. The second frame transmits all zeros.
- Reset mid-frame:
  - Stimulus: load 8'hC3, then assert RESET after 4 strobes.
  - Required: all outputs go to reset values immediately, and no DONE is generated. After release, loading 8'h81 transmits 1,0,0,0,0,0,0,1 and DONE follows.
